fifo_sync_param: RTL and testbench
==================================

# fifo_sync_param

Parametrised synchronous FIFO, the successor to the fixed 16×8 FIFO. It generalises width, depth and thresholds, and adds a first-word-fall-through (FWFT) read mode. It exposes an exact occupancy count plus almost-full and almost-empty flags, and signals overflow and underflow as one-cycle error pulses. It sits between any single-clock producer/consumer pair in the design and replaces the fixed-size FIFO in new datapaths.

## Interface
- DATA_WIDTH, 8, data bus width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = registered read mode; 1 = first-word-fall-through mode
- clock  in  1  single clock; all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- write_n  in  1  active-low write request
- data_in  in  DATA_WIDTH  write data
- read_n  in  1  active-low read request
- data_out  out  DATA_WIDTH  read data
- data_valid  out  1  data_out holds valid read data
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- full, empty  out  1 each  count==DEPTH / count==0
- almost_full, almost_empty  out  1 each  threshold flags
- over_flow, under_flow  out  1 each  one-cycle error pulses

## Operation
- Write accepted (wr_acc) = !write_n && (!full || rd_acc). Read accepted (rd_acc) = !read_n && !empty.
- When full, a simultaneous read+write is accepted for both; count is unchanged.
- When empty, a simultaneous read+write: the read is rejected (under_flow) and the write is accepted.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. Count changes by +1 on write-only, -1 on read-only, 0 on both.
- Count reaches DEPTH, so every one of DEPTH entries is usable.
- Flags are decoded combinationally from the registered count, with no extra lag.
- over_flow pulses high for the one cycle after an edge at which !write_n && !wr_acc. under_flow behaves the same way for reads.
- Rejected operations change no state other than the error pulse. No $display in RTL.
- FWFT=0: on an edge with rd_acc, data_out ← mem[rd_ptr] and data_valid ← 1. Otherwise data_valid ← 0 and data_out holds its value.
- FWFT=1: data_out = mem[rd_ptr] and data_valid = !empty, both combinational. read_n acts as a pop/acknowledge. data_out is don't-care while empty.
- Memory contents are not reset.

## Timing
- Reset values (asynchronous): pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, over_flow 0, under_flow 0, data_valid 0, data_out 0.
- Reset asserted mid-operation discards all contents immediately. The first accepted write after release lands in entry 0.
- Write→empty deassert: 1 edge. Write→readable: next cycle in FWFT, next read edge in FWFT=0.
- FWFT=0 read latency: data is valid in the cycle after the accepting edge.
- Full→read→full deassert: 1 edge. Back-to-back writes and reads are sustainable at 1 per cycle each.
- Wrap: rd_ptr==wr_ptr is ambiguous, so full/empty are resolved from count only, never from pointer compare.

## Structure
- Package fifo_pkg:
  - function cnt_width(depth) = $clog2(depth)+1
  - elaboration-time checks: DEPTH power of two, AF_LEVEL/AE_LEVEL in range (fatal on violation)
- Sub-module fifo_mem_dp: DEPTH×DATA_WIDTH array with a synchronous write port and an asynchronous read port.
- Pointers, count, flags, error pulses and the read-mode mux live in fifo_sync_param.

## Test plan
- Defaults, FWFT=0: reset, write 16 values 0x10..0x1F → full=1 and count=16 after 16th edge; 17th write → over_flow pulse for 1 cycle, count stays 16.
- Drain the full FIFO with 16 reads → data_out 0x10..0x1F in order, data_valid each following cycle; 17th read → under_flow pulse, empty=1, data_out holds 0x1F.
- Full FIFO plus read_n=0 and write_n=0 with data 0xAA for 1 cycle → count stays 16, 0xAA appears as the 16th subsequent read. Empty FIFO plus both → under_flow=1, count=1.
- Thresholds with AF_LEVEL=12, AE_LEVEL=2: almost_empty drops on the 3rd write; almost_full rises on the 12th write and falls after the read that brings count to 11.
- FWFT=1: write 0x5A into an empty FIFO → next cycle data_out=0x5A, data_valid=1; pop → empty=1 and data_valid=0 next cycle.
- Wrap and reset: 40 interleaved writes/reads with random gaps match a scoreboard across pointer wrap. Assert reset_n at count=7 → all outputs reach reset values without a clock edge, and the next write/read returns the newly written word.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the parametrised synchronous FIFO.
//   cnt_width(depth)            - width of an occupancy counter that can hold 0..depth
//   is_pow2(v)                  - true when v is a power of two and at least 2
//   levels_ok(depth, af, ae)    - true when both threshold levels are in range
// The predicates are evaluated at elaboration time by fifo_sync_param.
package fifo_pkg;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 32'sd2) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

  function automatic bit levels_ok(input int depth, input int af, input int ae);
    return (af >= 32'sd1) && (af <= depth) && (ae >= 32'sd0) && (ae <= depth - 32'sd1);
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: DEPTH x DATA_WIDTH storage array for the FIFO.
//   clock    - write clock
//   wr_en    - write enable, sampled on posedge
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - asynchronous read data at rd_addr
// Contents are deliberately not reset.
module fifo_mem_dp #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Synchronous write port
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with optional FWFT read mode.
//   clock, reset_n         - clock (posedge) and asynchronous active-low reset
//   write_n, data_in       - active-low write request and write data
//   read_n                 - active-low read request (pop/acknowledge in FWFT mode)
//   data_out, data_valid   - read data and its qualifier
//   count                  - occupancy 0..DEPTH
//   full, empty            - count==DEPTH / count==0
//   almost_full/empty      - count >= AF_LEVEL / count <= AE_LEVEL
//   over_flow, under_flow  - one-cycle pulses after a rejected write / read
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 32'sd2,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        write_n,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        read_n,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        data_valid,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic                        over_flow,
  output logic                        under_flow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_AF   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] CNT_AE   = CW'(AE_LEVEL);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $fatal(1, "fifo_sync_param: DEPTH must be a power of two and at least 2");
  end
  if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $fatal(1, "fifo_sync_param: AF_LEVEL must be 1..DEPTH and AE_LEVEL 0..DEPTH-1");
  end

  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  over_flow_r;
  logic                  under_flow_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  rd_acc_s;
  logic                  wr_acc_s;
  logic [DATA_WIDTH-1:0] mem_rd_s;

  // Pointers cannot tell full from empty after a wrap, so both come from count.
  assign full_s   = (count_r == CNT_FULL);
  assign empty_s  = (count_r == CNT_ZERO);
  assign rd_acc_s = !read_n && !empty_s;
  // A full FIFO can still take a write when a read frees a slot on the same edge.
  assign wr_acc_s = !write_n && (!full_s || rd_acc_s);

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clock   (clock),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (data_in),
    .rd_addr (rd_ptr_r),
    .rd_data (mem_rd_s)
  );

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Error pulses for the cycle following a rejected request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      over_flow_r  <= 1'b0;
      under_flow_r <= 1'b0;
    end else begin
      over_flow_r  <= !write_n && !wr_acc_s;
      under_flow_r <= !read_n && !rd_acc_s;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Head entry is presented continuously; read_n only pops it.
    assign data_out   = mem_rd_s;
    assign data_valid = !empty_s;
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  data_valid_r;

    // Registered read: capture head on an accepted read, otherwise hold
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        data_out_r   <= {DATA_WIDTH{1'b0}};
        data_valid_r <= 1'b0;
      end else if (rd_acc_s) begin
        data_out_r   <= mem_rd_s;
        data_valid_r <= 1'b1;
      end else begin
        data_valid_r <= 1'b0;
      end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
  end

  assign count        = count_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= CNT_AF);
  assign almost_empty = (count_r <= CNT_AE);
  assign over_flow    = over_flow_r;
  assign under_flow   = under_flow_r;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Testbench: two FIFO instances share one stimulus stream. dut0 is registered
// read mode with AF_LEVEL=12/AE_LEVEL=2, dut1 is FWFT with default thresholds.
// A queue-based reference model predicts every output of both.
module tb_fifo_sync_param;

  logic       clock;
  logic       reset_n;
  logic       write_n;
  logic       read_n;
  logic [7:0] data_in;

  logic [7:0] data_out0, data_out1;
  logic       data_valid0, data_valid1;
  logic [4:0] count0, count1;
  logic       full0, full1, empty0, empty1;
  logic       almost_full0, almost_full1, almost_empty0, almost_empty1;
  logic       over_flow0, over_flow1, under_flow0, under_flow1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] model_q[$];
  logic [7:0] exp_dout0;
  logic       exp_dv0;
  logic       exp_of;
  logic       exp_uf;

  fifo_sync_param #(
    .DATA_WIDTH (8), .DEPTH (16), .AF_LEVEL (12), .AE_LEVEL (2), .FWFT (0)
  ) dut0 (
    .clock        (clock),
    .reset_n      (reset_n),
    .write_n      (write_n),
    .data_in      (data_in),
    .read_n       (read_n),
    .data_out     (data_out0),
    .data_valid   (data_valid0),
    .count        (count0),
    .full         (full0),
    .empty        (empty0),
    .almost_full  (almost_full0),
    .almost_empty (almost_empty0),
    .over_flow    (over_flow0),
    .under_flow   (under_flow0)
  );

  fifo_sync_param #(
    .DATA_WIDTH (8), .DEPTH (16), .FWFT (1)
  ) dut1 (
    .clock        (clock),
    .reset_n      (reset_n),
    .write_n      (write_n),
    .data_in      (data_in),
    .read_n       (read_n),
    .data_out     (data_out1),
    .data_valid   (data_valid1),
    .count        (count1),
    .full         (full1),
    .empty        (empty1),
    .almost_full  (almost_full1),
    .almost_empty (almost_empty1),
    .over_flow    (over_flow1),
    .under_flow   (under_flow1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output of both instances against the model
  task automatic check_all();
    int n;
    n = model_q.size();
    check_value("count0", 32'(count0), 32'(n));
    check_value("count1", 32'(count1), 32'(n));
    check_value("full0", 32'(full0), 32'(n == 16));
    check_value("full1", 32'(full1), 32'(n == 16));
    check_value("empty0", 32'(empty0), 32'(n == 0));
    check_value("empty1", 32'(empty1), 32'(n == 0));
    check_value("afull0", 32'(almost_full0), 32'(n >= 12));
    check_value("afull1", 32'(almost_full1), 32'(n >= 14));
    check_value("aempty0", 32'(almost_empty0), 32'(n <= 2));
    check_value("aempty1", 32'(almost_empty1), 32'(n <= 2));
    check_value("oflow0", 32'(over_flow0), 32'(exp_of));
    check_value("oflow1", 32'(over_flow1), 32'(exp_of));
    check_value("uflow0", 32'(under_flow0), 32'(exp_uf));
    check_value("uflow1", 32'(under_flow1), 32'(exp_uf));
    check_value("dvalid0", 32'(data_valid0), 32'(exp_dv0));
    check_value("dout0", 32'(data_out0), 32'(exp_dout0));
    check_value("dvalid1", 32'(data_valid1), 32'(n != 0));
    if (n != 0) begin
      check_value("dout1", 32'(data_out1), 32'(model_q[0]));
    end
  endtask

  // One clock of stimulus; model applies the acceptance rules to pre-edge state
  task automatic step(input logic wn, input logic rn, input logic [7:0] d);
    bit rd_acc;
    bit wr_acc;
    write_n = wn;
    read_n  = rn;
    data_in = d;
    rd_acc = !rn && (model_q.size() > 0);
    wr_acc = !wn && ((model_q.size() < 16) || rd_acc);
    @(posedge clock);
    if (rd_acc) begin
      exp_dout0 = model_q.pop_front();
      exp_dv0   = 1'b1;
    end else begin
      exp_dv0 = 1'b0;
    end
    if (wr_acc) begin
      model_q.push_back(d);
    end
    exp_of = !wn && !wr_acc;
    exp_uf = !rn && !rd_acc;
    #1;
    check_all();
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_dout0 = 8'h00;
    exp_dv0   = 1'b0;
    exp_of    = 1'b0;
    exp_uf    = 1'b0;
  endtask

  task automatic drain();
    while (model_q.size() > 0) begin
      step(1'b1, 1'b0, 8'h00);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    write_n = 1'b1;
    read_n  = 1'b1;
    data_in = 8'h00;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    @(negedge clock);
    reset_n = 1'b1;

    // Fill to full, then one rejected write
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(8'h10 + i));
    end
    step(1'b0, 1'b1, 8'hEE);
    step(1'b1, 1'b1, 8'h00);

    // Drain in order, then one rejected read; data_out0 holds last word
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 8'h00);
    end
    step(1'b1, 1'b1, 8'h00);

    // Simultaneous read+write while full
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
    end
    step(1'b0, 1'b0, 8'hAA);
    drain();

    // Simultaneous read+write while empty: read rejected, write lands
    step(1'b0, 1'b0, 8'h33);
    step(1'b1, 1'b0, 8'h00);

    // Threshold crossings up to 12 and back down to 10
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 8'(8'h40 + i));
    end
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    drain();

    // FWFT fall-through and pop
    step(1'b0, 1'b1, 8'h5A);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h00);

    // Random interleaving with idle gaps, crossing pointer wrap
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step(1'b1, 1'b1, 8'h00);
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
      end
    end

    // Reset mid-operation at count 7, checked without a clock edge
    drain();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 8'(8'h70 + i));
    end
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h77);
    reset_n = 1'b0;
    model_reset();
    #2;
    check_all();
    reset_n = 1'b1;
    step(1'b0, 1'b1, 8'hC3);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
